// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants for register-file geometry and result latencies
package cpu_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int LAT_W    = 3;

  // Result latencies driven onto ID_Latency_i by the decoder.
  localparam logic [LAT_W-1:0] LAT_ALU  = 3'd0;
  localparam logic [LAT_W-1:0] LAT_LOAD = 3'd1;
  localparam logic [LAT_W-1:0] LAT_MUL  = 3'd3;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage operand/issue bundle between decoder and hazard scoreboard
interface hazard_scoreboard_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0]   ID_RSaddr_i;
  logic [ADDR_W-1:0]   ID_RTaddr_i;
  logic                ID_RSuse_i;
  logic                ID_RTuse_i;
  logic [ADDR_W-1:0]   ID_RDaddr_i;
  logic                ID_RegWrite_i;
  logic [LAT_W-1:0]    ID_Latency_i;
  logic                issue_i;
  logic                Stall_o;
  logic [NUM_REGS-1:0] Pending_o;

  // Decoder side: presents the ID instruction, receives the stall.
  modport master (
    output ID_RSaddr_i, ID_RTaddr_i, ID_RSuse_i, ID_RTuse_i,
    output ID_RDaddr_i, ID_RegWrite_i, ID_Latency_i, issue_i,
    input  Stall_o, Pending_o
  );

  // Scoreboard side.
  modport slave (
    input  ID_RSaddr_i, ID_RTaddr_i, ID_RSuse_i, ID_RTuse_i,
    input  ID_RDaddr_i, ID_RegWrite_i, ID_Latency_i, issue_i,
    output Stall_o, Pending_o
  );

endinterface

// File: rtl/scoreboard_entry.sv
// rtl/scoreboard_entry.sv - one per-register latency countdown with load and nonzero flag
module scoreboard_entry
  import cpu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] lat_i,
  output logic [LAT_W-1:0] cnt_o,
  output logic             busy_o
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  // Next count: a fresh issue reloads, otherwise count down and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = lat_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
  end

  // Counter register; reset discards any outstanding result immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW/WAW stall generation from per-register result countdowns
module hazard_scoreboard
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  hazard_scoreboard_if.slave sb
);

  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:1] load_en;
  logic [LAT_W-1:0]    rs_cnt;
  logic [LAT_W-1:0]    rt_cnt;
  logic [LAT_W-1:0]    rd_cnt;
  logic                raw_stall;
  logic                waw_stall;
  logic                stall;
  logic                eff_issue;

  // Register zero is hard-wired, so it never has a pending result.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  generate
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
      scoreboard_entry u_entry (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load_en[r]),
        .lat_i  (sb.ID_Latency_i),
        .cnt_o  (cnt[r]),
        .busy_o (busy[r])
      );
    end
  endgenerate

  // Read the remaining latency of each operand and of the destination.
  always_comb begin
    rs_cnt = cnt[sb.ID_RSaddr_i];
    rt_cnt = cnt[sb.ID_RTaddr_i];
    rd_cnt = cnt[sb.ID_RDaddr_i];
  end

  // Stall on a source not yet forwardable, or on a destination whose older
  // write would land after this one.
  always_comb begin
    raw_stall = (sb.ID_RSuse_i && (sb.ID_RSaddr_i != '0) && (rs_cnt != '0)) ||
                (sb.ID_RTuse_i && (sb.ID_RTaddr_i != '0) && (rt_cnt != '0));
    waw_stall = sb.ID_RegWrite_i && (sb.ID_RDaddr_i != '0) && (rd_cnt > sb.ID_Latency_i);
    stall     = raw_stall || waw_stall;
    eff_issue = sb.issue_i && !stall;
  end

  // One-hot load enable for the destination of an issue that actually advances.
  always_comb begin
    load_en = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      load_en[r] = eff_issue && sb.ID_RegWrite_i && (sb.ID_RDaddr_i == ADDR_W'(r));
    end
  end

  assign sb.Stall_o   = stall;
  assign sb.Pending_o = busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if sb_if ();

  hazard_scoreboard dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sb_if.slave)
  );

  typedef struct packed {
    logic        stall;
    logic [31:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   mcnt[32];
  int   checks   = 0;
  int   failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.stall = ((sb_if.ID_RSuse_i && sb_if.ID_RSaddr_i != 0 && mcnt[sb_if.ID_RSaddr_i] != 0) ||
               (sb_if.ID_RTuse_i && sb_if.ID_RTaddr_i != 0 && mcnt[sb_if.ID_RTaddr_i] != 0) ||
               (sb_if.ID_RegWrite_i && sb_if.ID_RDaddr_i != 0 &&
                mcnt[sb_if.ID_RDaddr_i] > int'(sb_if.ID_Latency_i)));
    e.pend = '0;
    for (int r = 1; r < 32; r++) e.pend[r] = (mcnt[r] != 0);
    return e;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) mcnt[r] = 0;
  endfunction

  // Drive one ID instruction at the falling edge, check outputs, then clock it.
  task automatic step(input string tag,
                      input logic [4:0] rs, input logic rsu,
                      input logic [4:0] rt, input logic rtu,
                      input logic [4:0] rd, input logic rw,
                      input logic [2:0] lat, input logic iss,
                      output logic st, output logic [31:0] pend);
    exp_t e;
    exp_t g;
    sb_if.ID_RSaddr_i   = rs;
    sb_if.ID_RSuse_i    = rsu;
    sb_if.ID_RTaddr_i   = rt;
    sb_if.ID_RTuse_i    = rtu;
    sb_if.ID_RDaddr_i   = rd;
    sb_if.ID_RegWrite_i = rw;
    sb_if.ID_Latency_i  = lat;
    sb_if.issue_i       = iss;
    e = model_out();
    exp_q.push_back(e);
    #1;
    g = exp_q.pop_front();
    check_eq({tag, "_stall"}, {31'd0, sb_if.Stall_o}, {31'd0, g.stall});
    check_eq({tag, "_pend"}, sb_if.Pending_o, g.pend);
    st   = sb_if.Stall_o;
    pend = sb_if.Pending_o;
    @(posedge clk);
    for (int r = 1; r < 32; r++) begin
      if (iss && !e.stall && rw && rd == 5'(r)) mcnt[r] = int'(lat);
      else if (mcnt[r] != 0) mcnt[r] = mcnt[r] - 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag, output logic st, output logic [31:0] pend);
    step(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, st, pend);
  endtask

  initial begin
    logic        st;
    logic [31:0] pend;
    int          n;

    model_clear();
    sb_if.ID_RSaddr_i = '0; sb_if.ID_RTaddr_i = '0; sb_if.ID_RSuse_i = 1'b0;
    sb_if.ID_RTuse_i = 1'b0; sb_if.ID_RDaddr_i = '0; sb_if.ID_RegWrite_i = 1'b0;
    sb_if.ID_Latency_i = '0; sb_if.issue_i = 1'b0;

    #2 rst = 1'b1;
    #1;
    check_eq("reset_stall", {31'd0, sb_if.Stall_o}, 32'd0);
    check_eq("reset_pend", sb_if.Pending_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Load-use: exactly one stall cycle.
    step("ld_issue", 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, LAT_LOAD, 1'b1, st, pend);
    n = 0;
    do begin
      step("ld_dep", 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, LAT_ALU, 1'b1, st, pend);
      if (st) n++;
    end while (st && n < 10);
    check_eq("load_use_stalls", n, 32'd1);

    // Multiply: dependent holds issue_i high through three stall cycles.
    step("mul_issue", 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, LAT_MUL, 1'b1, st, pend);
    n = 0;
    do begin
      step("mul_dep", 5'd0, 1'b0, 5'd10, 1'b1, 5'd11, 1'b1, 3'd2, 1'b1, st, pend);
      if (st) n++;
    end while (st && n < 10);
    check_eq("mul_stalls", n, 32'd3);
    idle("mul_after", st, pend);
    check_eq("mul_r11_loaded_once", {31'd0, pend[11]}, 32'd1);
    idle("mul_drain", st, pend);

    // WAW: short op behind long op to r12 waits; equal latency does not.
    step("waw_long", 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, LAT_MUL, 1'b1, st, pend);
    n = 0;
    do begin
      step("waw_short", 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, LAT_ALU, 1'b1, st, pend);
      if (st) n++;
    end while (st && n < 10);
    check_eq("waw_stalls", n, 32'd3);
    step("waw_long2", 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, LAT_MUL, 1'b1, st, pend);
    step("waw_equal", 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, LAT_MUL, 1'b1, st, pend);
    check_eq("waw_equal_nostall", {31'd0, st}, 32'd0);
    repeat (4) idle("waw_drain", st, pend);

    // Register zero never tracks a result.
    step("r0_issue", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 3'd7, 1'b1, st, pend);
    step("r0_read", 5'd0, 1'b1, 5'd0, 1'b1, 5'd1, 1'b1, LAT_ALU, 1'b1, st, pend);
    check_eq("r0_stall", {31'd0, st}, 32'd0);
    check_eq("r0_pend0", {31'd0, pend[0]}, 32'd0);

    // Reload: issue to r3 while its counter is 1 restarts it at 2.
    step("rl_first", 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd2, 1'b1, st, pend);
    idle("rl_gap", st, pend);
    step("rl_again", 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 3'd2, 1'b1, st, pend);
    check_eq("rl_nostall", {31'd0, st}, 32'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      idle("rl_count", st, pend);
      if (pend[3]) n++;
    end
    check_eq("rl_pend_cycles", n, 32'd2);

    // Random traffic over a small register window.
    for (int i = 0; i < 300; i++) begin
      logic [2:0] lat_sel;
      lat_sel = 3'($urandom_range(0, 3));
      step("rnd", 5'($urandom_range(0, 15)), 1'($urandom), 5'($urandom_range(0, 15)),
           1'($urandom), 5'($urandom_range(0, 15)), 1'($urandom),
           (lat_sel == 3'd0) ? 3'd0 : (lat_sel == 3'd1) ? 3'd1 : (lat_sel == 3'd2) ? 3'd3 : 3'd7,
           1'($urandom), st, pend);
    end
    repeat (8) idle("rnd_drain", st, pend);

    // Asynchronous reset mid-cycle with r5 counting down from 3.
    step("ar_issue", 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, LAT_MUL, 1'b1, st, pend);
    sb_if.ID_RSaddr_i = 5'd5; sb_if.ID_RSuse_i = 1'b1;
    sb_if.ID_RegWrite_i = 1'b0; sb_if.issue_i = 1'b0;
    #1;
    check_eq("ar_before_stall", {31'd0, sb_if.Stall_o}, 32'd1);
    check_eq("ar_before_pend5", {31'd0, sb_if.Pending_o[5]}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("ar_stall", {31'd0, sb_if.Stall_o}, 32'd0);
    check_eq("ar_pend", sb_if.Pending_o, 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step("ar_after", 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, LAT_ALU, 1'b1, st, pend);
    check_eq("ar_after_stall", {31'd0, st}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-hazard scoreboard for the pipelined CPU: the producer-side counterpart of the forwarding path. It records the destination register and result latency of each instruction issued from ID to EX, and counts down until that result can be forwarded. It raises a stall to ID when a source operand, or a write-after-write destination, is not yet forwardable. It sits beside the ID/EX pipeline register and covers loads and multi-cycle units that the forwarding muxes alone cannot cover.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers; register 0 is hard-wired zero.
- ADDR_W, 5, register address width.
- LAT_W, 3, latency counter width; maximum latency is 7.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- ID_RSaddr_i  in  ADDR_W  source register rs of the instruction in ID.
- ID_RTaddr_i  in  ADDR_W  source register rt of the instruction in ID.
- ID_RSuse_i  in  1  instruction in ID reads rs.
- ID_RTuse_i  in  1  instruction in ID reads rt.
- ID_RDaddr_i  in  ADDR_W  destination register of the instruction in ID.
- ID_RegWrite_i  in  1  instruction in ID writes RD.
- ID_Latency_i  in  LAT_W  cycles after issue during which a dependent in ID must stall (ALU 0, load 1, multiply 3).
- issue_i  in  1  the instruction in ID advances to EX at this edge; upstream request, gated internally.
- Stall_o  out  1  hold PC and IF/ID; bubble into ID/EX.
- Pending_o  out  NUM_REGS  bit r is set while counter r is nonzero; bit 0 is always 0.

## Operation
- State: one LAT_W-bit countdown cnt[r] per register r = 1..31. There is no storage for r = 0.
- Effective issue: eff_issue = issue_i & ~Stall_o. An issue_i asserted while stalled has no effect.
- RAW stall: (ID_RSuse_i & ID_RSaddr_i != 0 & cnt[ID_RSaddr_i] != 0) | (ID_RTuse_i & ID_RTaddr_i != 0 & cnt[ID_RTaddr_i] != 0).
- WAW stall: ID_RegWrite_i & ID_RDaddr_i != 0 & cnt[ID_RDaddr_i] > ID_Latency_i. This prevents a short op from overtaking a long op to the same register.
- Stall_o = RAW stall | WAW stall.
- Per-register update at each edge, in priority order:
  - If eff_issue & ID_RegWrite_i & ID_RDaddr_i == r & r != 0, then cnt[r] <= ID_Latency_i. Issue overrides decrement.
  - Else if cnt[r] != 0, then cnt[r] <= cnt[r] - 1.
  - Else hold at 0. The counter never wraps below 0.
- ID_Latency_i = 0 on issue leaves the entry at 0: no stall, and the forwarding unit handles the dependency.
- An issue with RDaddr 0, or with RegWrite low, changes no state.

## Timing
- Stall_o and Pending_o are combinational from current state and ID inputs. There is zero-cycle latency to ID.
- If an issue at edge t has latency L ≥ 1, cnt = L after edge t. A dependent in ID stalls for L cycles and issues at the (L+1)-th cycle after t.
- Re-issue to a register with a nonzero counter reloads the counter. This is legal only when it passes the WAW check.
- Reset: every cnt is cleared at once on rst_i high, independent of clk_i. While reset is held, Stall_o = 0 and Pending_o = 0.
- Reset mid-countdown discards all pending state. Behaviour after release is the same as after power-up.
- All counters decrement in parallel every cycle, including cycles with Stall_o = 1. Latency is measured in cycles, not in issues.

## Structure
- Shared package cpu_pkg holds:
  - ADDR_W, NUM_REGS, LAT_W.
  - Latency constants LAT_ALU = 0, LAT_LOAD = 1, LAT_MUL = 3. The decoder drives ID_Latency_i from these.
- Sub-module scoreboard_entry contains one counter with its load/decrement logic and a nonzero flag. It is instantiated for r = 1..NUM_REGS-1 by a generate loop.
- Top level holds:
  - the 32:1 read muxes for rs, rt and rd;
  - the stall compare;
  - the issue decode to one-hot load enables.

## Test plan
- Reset: assert rst_i asynchronously mid-cycle with cnt[5] = 3 → Pending_o = 0 and Stall_o = 0 immediately, with no clock edge needed.
- Load-use: issue a load to r8 with L = 1, then an instruction in ID reading rs = r8 → Stall_o = 1 for exactly 1 cycle, and the dependent issues on the next edge.
- Multi-cycle with gated issue: issue with L = 3 to r10; a dependent with rt = r10 drives issue_i = 1 throughout → Stall_o is high for 3 cycles and the ignored issues do not reload any counter.
- WAW: r12 is pending with cnt = 3; the ID instruction writes r12 with L = 0 and no sources → Stall_o = 1 until cnt ≤ 0. With L = 3, the same case gives no stall.
- Register zero: issue to r0 with L = 7, then read r0 → Pending_o[0] = 0 and Stall_o = 0.
- Reload: r3 cnt = 1 and a new issue to r3 with L = 2 on the same edge → cnt[3] = 2 (issue wins), and Pending_o[3] stays high for 2 more cycles.
